// File: rtl/cmac_pkg.sv
// Shared constants and helpers for the complex fixed-point MAC pipeline.
// Default format is Q3.3 with a 4-bit accumulator guard.
package cmac_pkg;

  localparam int QI_DEF    = 3;
  localparam int QF_DEF    = 3;
  localparam int GUARD_DEF = 4;

  localparam int W  = QI_DEF + QF_DEF;
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 1 + GUARD_DEF;

  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  localparam int MAX_W = sat_max(W);
  localparam int MIN_W = sat_min(W);

endpackage

// File: rtl/cmac_fixed_pipe_if.sv
// Operand/result stream bundle for cmac_fixed_pipe.
// The slave side is the MAC; the master side is the producer/consumer pair.
interface cmac_fixed_pipe_if #(
  parameter int W = 6
);
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic signed [W-1:0] a_Re;
  logic signed [W-1:0] a_Im;
  logic signed [W-1:0] b_Re;
  logic signed [W-1:0] b_Im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] y_Re;
  logic signed [W-1:0] y_Im;
  logic                overflow;
  logic                bad_rep;

  modport master (
    output in_valid, in_last, a_Re, a_Im, b_Re, b_Im, out_ready,
    input  in_ready, out_valid, y_Re, y_Im, overflow, bad_rep
  );

  modport slave (
    input  in_valid, in_last, a_Re, a_Im, b_Re, b_Im, out_ready,
    output in_ready, out_valid, y_Re, y_Im, overflow, bad_rep
  );
endinterface

// File: rtl/cmac_round_sat.sv
// Reduces an AW-bit accumulator to a W-bit Q(QI.QF) value: optional half-LSB
// rounding, QF arithmetic shift, then clamp or wrap if the result does not fit.
module cmac_round_sat
  import cmac_pkg::*;
#(
  parameter int W     = 6,
  parameter int QF    = 3,
  parameter int AW    = 17,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic signed [AW-1:0] acc_i,
  output logic signed [W-1:0]  y_o,
  output logic                 bad_rep_o,
  output logic                 rnd_ovf_o
);

  localparam int RW = AW - QF;
  localparam logic signed [AW-1:0] HALF  = (ROUND != 0) ? (AW'(1) << (QF - 1)) : '0;
  localparam logic signed [W-1:0]  Y_MAX = W'(sat_max(W));
  localparam logic signed [W-1:0]  Y_MIN = W'(sat_min(W));

  logic signed [AW-1:0] rsum;
  logic signed [RW-1:0] r;
  logic [RW-W:0]        top_bits;
  logic                 fits;
  logic                 unused_lsbs;

  assign rsum        = acc_i + HALF;
  // HALF is non-negative, so only a positive operand can wrap to negative
  assign rnd_ovf_o   = ~acc_i[AW-1] & rsum[AW-1];
  assign r           = rsum[AW-1:QF];
  assign unused_lsbs = ^rsum[QF-1:0];

  assign top_bits  = r[RW-1:W-1];
  assign fits      = (&top_bits) | ~(|top_bits);
  assign bad_rep_o = ~fits;

  always_comb begin
    y_o = r[W-1:0];
    if (!fits && (SAT != 0)) begin
      y_o = r[RW-1] ? Y_MIN : Y_MAX;
    end
  end

endmodule

// File: rtl/cmac_fixed_pipe.sv
// Four-stage complex MAC: S1 products, S2 complex combine, S3 frame accumulate,
// S4 round/saturate. One global advance signal stalls every stage together.
module cmac_fixed_pipe
  import cmac_pkg::*;
#(
  parameter int QI        = QI_DEF,
  parameter int QF        = QF_DEF,
  parameter int ACC_GUARD = GUARD_DEF,
  parameter int ROUND     = 1,
  parameter int SAT       = 1
) (
  input  logic             clk,
  input  logic             rst,
  cmac_fixed_pipe_if.slave bus
);

  localparam int DW  = QI + QF;
  localparam int DPW = 2 * DW;
  localparam int SW  = DPW + 1;
  localparam int DAW = SW + ACC_GUARD;

  logic adv;
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  logic                  s1_valid_q, s1_last_q;
  logic signed [DPW-1:0] rr_q, ii_q, ri_q, ir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_last_q  <= bus.in_last;
      if (bus.in_valid) begin
        rr_q <= DPW'(bus.a_Re) * DPW'(bus.b_Re);
        ii_q <= DPW'(bus.a_Im) * DPW'(bus.b_Im);
        ri_q <= DPW'(bus.a_Re) * DPW'(bus.b_Im);
        ir_q <= DPW'(bus.a_Im) * DPW'(bus.b_Re);
      end
    end
  end

  logic                 s2_valid_q, s2_last_q;
  logic signed [SW-1:0] pr_q, pi_q, pr_d, pi_d;

  assign pr_d = SW'(rr_q) - SW'(ii_q);
  assign pi_d = SW'(ri_q) + SW'(ir_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      pr_q <= '0;
      pi_q <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q) begin
        pr_q <= pr_d;
        pi_q <= pi_d;
      end
    end
  end

  logic                  s3_last_q, first_q, acc_ovf_q, acc_ovf_d;
  logic signed [DAW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic signed [DAW-1:0] ext_re, ext_im, sum_re, sum_im;
  logic                  add_ovf_re, add_ovf_im;

  assign ext_re = DAW'(pr_q);
  assign ext_im = DAW'(pi_q);
  assign sum_re = acc_re_q + ext_re;
  assign sum_im = acc_im_q + ext_im;

  // Sign rule on the wrapping add; a frame's first beat loads and cannot overflow
  assign add_ovf_re = ~first_q & (acc_re_q[DAW-1] == ext_re[DAW-1]) & (sum_re[DAW-1] != acc_re_q[DAW-1]);
  assign add_ovf_im = ~first_q & (acc_im_q[DAW-1] == ext_im[DAW-1]) & (sum_im[DAW-1] != acc_im_q[DAW-1]);
  assign acc_re_d   = first_q ? ext_re : sum_re;
  assign acc_im_d   = first_q ? ext_im : sum_im;
  assign acc_ovf_d  = (first_q ? 1'b0 : acc_ovf_q) | add_ovf_re | add_ovf_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_last_q <= 1'b0;
      first_q   <= 1'b1;
      acc_ovf_q <= 1'b0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
    end else if (adv) begin
      s3_last_q <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        acc_re_q  <= acc_re_d;
        acc_im_q  <= acc_im_d;
        acc_ovf_q <= acc_ovf_d;
        first_q   <= s2_last_q;
      end
    end
  end

  logic signed [DW-1:0] y_re_d, y_im_d, y_re_q, y_im_q;
  logic                 bad_re, bad_im, rnd_ovf_re, rnd_ovf_im;
  logic                 out_valid_q, ovf_out_q, bad_out_q;

  cmac_round_sat #(.W(DW), .QF(QF), .AW(DAW), .ROUND(ROUND), .SAT(SAT)) u_rs_re (
    .acc_i(acc_re_q), .y_o(y_re_d), .bad_rep_o(bad_re), .rnd_ovf_o(rnd_ovf_re)
  );

  cmac_round_sat #(.W(DW), .QF(QF), .AW(DAW), .ROUND(ROUND), .SAT(SAT)) u_rs_im (
    .acc_i(acc_im_q), .y_o(y_im_d), .bad_rep_o(bad_im), .rnd_ovf_o(rnd_ovf_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      ovf_out_q   <= 1'b0;
      bad_out_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s3_last_q;
      if (s3_last_q) begin
        y_re_q    <= y_re_d;
        y_im_q    <= y_im_d;
        ovf_out_q <= acc_ovf_q | rnd_ovf_re | rnd_ovf_im;
        bad_out_q <= bad_re | bad_im;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y_Re      = y_re_q;
  assign bus.y_Im      = y_im_q;
  assign bus.overflow  = ovf_out_q;
  assign bus.bad_rep   = bad_out_q;

endmodule
